// File: rtl/robo_controller_if.sv
// Bundle of all non-clock/reset signals between the robot sequencer and its
// environment (gamepad decoder on one side, map memory on the other).
interface robo_controller_if;
    logic        manual_mode;
    logic [11:0] gamepad_input;
    logic        head;
    logic        left;
    logic        under;
    logic        barrier;
    logic        sense_valid;
    logic        cmd_ack;
    logic        sense_req;
    logic        cmd_valid;
    logic [2:0]  cmd;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] steps;

    // environment side: drives mode, buttons, sensors and acks
    modport master (
        output manual_mode, gamepad_input, head, left, under, barrier,
               sense_valid, cmd_ack,
        input  sense_req, cmd_valid, cmd, busy, done, error, steps
    );

    // sequencer side
    modport slave (
        input  manual_mode, gamepad_input, head, left, under, barrier,
               sense_valid, cmd_ack,
        output sense_req, cmd_valid, cmd, busy, done, error, steps
    );
endinterface

// File: rtl/robo_controller.sv
// Maze robot motion sequencer: left-hand wall following in autonomous mode,
// edge-detected gamepad forwarding in manual mode, one command in flight.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// S_IDLE       | pick mode: manual waits for a button edge, auto starts pacing
// S_WAIT_STEP  | pacing gap of STEP_CYCLES cycles between autonomous steps
// S_SENSE      | one-cycle sense_req pulse
// S_WAIT_SENSE | wait for sensor snapshot, bounded by TIMEOUT
// S_DECIDE     | apply wall-following rules to the latched snapshot
// S_ISSUE      | hold cmd_valid/cmd until acked, bounded by TIMEOUT
// S_DONE       | goal reached, parked until manual mode
// S_ERROR      | handshake timeout, parked until reset
module robo_controller #(
    parameter int unsigned STEP_CYCLES = 4,
    parameter int unsigned TIMEOUT     = 15
) (
    input  logic             i_clock,
    input  logic             i_reset,
    robo_controller_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_STEP, S_SENSE, S_WAIT_SENSE,
        S_DECIDE, S_ISSUE, S_DONE, S_ERROR
    } state_t;

    localparam logic [2:0] CMD_NONE   = 3'd0;
    localparam logic [2:0] CMD_FWD    = 3'd1;
    localparam logic [2:0] CMD_LEFT   = 3'd2;
    localparam logic [2:0] CMD_RIGHT  = 3'd3;
    localparam logic [2:0] CMD_REMOVE = 3'd4;

    localparam logic [7:0] STEP_LOAD = 8'(STEP_CYCLES - 1);
    localparam logic [7:0] TO_LOAD   = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_cnt;
    logic        w_cnt_tc;
    logic [3:0]  r_pad_s;
    logic [3:0]  r_pad_prev;
    logic [3:0]  w_pad_rise;
    logic        r_head;
    logic        r_left;
    logic        r_under;
    logic        r_barrier;
    logic        r_last_left;
    logic        r_mode_prev;
    logic [2:0]  r_cmd;
    logic [2:0]  w_cmd_next;
    logic [15:0] r_steps;
    logic        w_ack;
    logic        w_unused_pad;

    // The buttons are registered once before the edge compare, so an edge
    // is acted on one cycle after the press is first sampled.
    assign w_pad_rise   = r_pad_s & ~r_pad_prev;
    assign w_cnt_tc     = (r_cnt == 8'd0);
    assign w_ack        = (r_state == S_ISSUE) && bus.cmd_ack;
    assign w_unused_pad = ^bus.gamepad_input[11:4];

    // State register plus the shared pacing/timeout down-counter, reloaded on every state change
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                case (w_next)
                    S_WAIT_STEP:           r_cnt <= STEP_LOAD;
                    S_WAIT_SENSE, S_ISSUE: r_cnt <= TO_LOAD;
                    default:               r_cnt <= '0;
                endcase
            end else if (!w_cnt_tc) begin
                r_cnt <= r_cnt - 8'd1;
            end
        end
    end

    // Datapath: button history, sensor snapshot, pending command, step count, last_left
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_pad_s     <= '0;
            r_pad_prev  <= '0;
            r_mode_prev <= 1'b0;
            r_head      <= 1'b0;
            r_left      <= 1'b0;
            r_under     <= 1'b0;
            r_barrier   <= 1'b0;
            r_cmd       <= CMD_NONE;
            r_steps     <= '0;
            r_last_left <= 1'b0;
        end else begin
            r_pad_s     <= bus.gamepad_input[3:0];
            r_pad_prev  <= r_pad_s;
            r_mode_prev <= bus.manual_mode;
            if (r_state == S_WAIT_SENSE && bus.sense_valid) begin
                r_head    <= bus.head;
                r_left    <= bus.left;
                r_under   <= bus.under;
                r_barrier <= bus.barrier;
            end
            if (w_next == S_ISSUE && r_state != S_ISSUE) begin
                r_cmd <= w_cmd_next;
            end
            if (w_ack) begin
                if (r_steps != 16'hFFFF) begin
                    r_steps <= r_steps + 16'd1;
                end
                r_last_left <= (r_cmd == CMD_LEFT);
            end
            // switching to manual forgets the previous turn history
            if (bus.manual_mode && !r_mode_prev) begin
                r_last_left <= 1'b0;
            end
        end
    end

    // Next-state and command selection
    always_comb begin
        w_next     = r_state;
        w_cmd_next = CMD_NONE;
        case (r_state)
            S_IDLE: begin
                if (bus.manual_mode) begin
                    if (w_pad_rise[0]) begin
                        w_next = S_ISSUE; w_cmd_next = CMD_FWD;
                    end else if (w_pad_rise[1]) begin
                        w_next = S_ISSUE; w_cmd_next = CMD_LEFT;
                    end else if (w_pad_rise[2]) begin
                        w_next = S_ISSUE; w_cmd_next = CMD_RIGHT;
                    end else if (w_pad_rise[3]) begin
                        w_next = S_ISSUE; w_cmd_next = CMD_REMOVE;
                    end
                end else begin
                    w_next = S_WAIT_STEP;
                end
            end
            S_WAIT_STEP: begin
                if (bus.manual_mode)   w_next = S_IDLE;
                else if (w_cnt_tc)     w_next = S_SENSE;
            end
            S_SENSE: w_next = S_WAIT_SENSE;
            S_WAIT_SENSE: begin
                if (bus.sense_valid)   w_next = S_DECIDE;
                else if (w_cnt_tc)     w_next = S_ERROR;
            end
            S_DECIDE: begin
                if (r_under) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_ISSUE;
                    if (r_barrier)                    w_cmd_next = CMD_REMOVE;
                    else if (!r_left && !r_last_left) w_cmd_next = CMD_LEFT;
                    else if (!r_head)                 w_cmd_next = CMD_FWD;
                    else                              w_cmd_next = CMD_RIGHT;
                end
            end
            S_ISSUE: begin
                if (bus.cmd_ack)       w_next = S_IDLE;
                else if (w_cnt_tc)     w_next = S_ERROR;
            end
            S_DONE: begin
                if (bus.manual_mode)   w_next = S_IDLE;
            end
            S_ERROR: w_next = S_ERROR;
            default: w_next = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the state
    always_comb begin
        bus.sense_req = (r_state == S_SENSE);
        bus.cmd_valid = (r_state == S_ISSUE);
        bus.cmd       = (r_state == S_ISSUE) ? r_cmd : CMD_NONE;
        bus.busy      = !(r_state == S_IDLE || r_state == S_DONE || r_state == S_ERROR);
        bus.done      = (r_state == S_DONE);
        bus.error     = (r_state == S_ERROR);
        bus.steps     = r_steps;
    end
endmodule

// File: tb/tb_robo_controller.sv
// Directed bench for robo_controller with default STEP_CYCLES=4, TIMEOUT=15.
module tb_robo_controller;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;

    robo_controller_if bus();

    robo_controller #(.STEP_CYCLES(4), .TIMEOUT(15)) dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Acts as a zero-latency map memory for one autonomous step; cyc counts
    // clock edges from the call until cmd_valid is seen.
    task automatic serve(input logic h, input logic l, input logic u, input logic b,
                         input logic want_cmd, output int cyc, output logic [2:0] c);
        cyc = 0;
        c = '0;
        while (bus.sense_req !== 1'b1 && cyc < 40) begin step(); cyc++; end
        step(); cyc++;
        bus.head = h; bus.left = l; bus.under = u; bus.barrier = b;
        bus.sense_valid = 1'b1;
        step(); cyc++;
        bus.sense_valid = 1'b0;
        if (want_cmd) begin
            while (bus.cmd_valid !== 1'b1 && cyc < 60) begin step(); cyc++; end
            c = bus.cmd;
            bus.cmd_ack = 1'b1;
            step();
            bus.cmd_ack = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        logic [2:0] c;
        logic seen;

        bus.manual_mode = 1'b0; bus.gamepad_input = '0;
        bus.head = 1'b0; bus.left = 1'b0; bus.under = 1'b0; bus.barrier = 1'b0;
        bus.sense_valid = 1'b0; bus.cmd_ack = 1'b0;
        repeat (3) step();

        chk("rst_sense_req", 32'(bus.sense_req), 0);
        chk("rst_cmd_valid", 32'(bus.cmd_valid), 0);
        chk("rst_cmd",       32'(bus.cmd), 0);
        chk("rst_busy",      32'(bus.busy), 0);
        chk("rst_done",      32'(bus.done), 0);
        chk("rst_error",     32'(bus.error), 0);
        chk("rst_steps",     32'(bus.steps), 0);

        // corridor: cmd_valid on the 8th edge after release, then every 9 cycles
        rst_n = 1'b1;
        serve(0, 1, 0, 0, 1, cyc, c);
        chk("corr1_latency", 32'(cyc), 8);
        chk("corr1_cmd",     32'(c), 1);
        chk("corr1_steps",   32'(bus.steps), 1);
        chk("corr1_cmd_off", 32'(bus.cmd), 0);
        serve(0, 1, 0, 0, 1, cyc, c);
        chk("corr2_period",  32'(cyc + 1), 9);
        chk("corr2_cmd",     32'(c), 1);
        chk("corr2_steps",   32'(bus.steps), 2);
        serve(0, 1, 0, 0, 1, cyc, c);
        chk("corr3_cmd",     32'(c), 1);
        chk("corr3_steps",   32'(bus.steps), 3);

        // left turn, then last_left forces forward, then left is allowed again
        serve(0, 0, 0, 0, 1, cyc, c);
        chk("left1_cmd", 32'(c), 2);
        serve(0, 0, 0, 0, 1, cyc, c);
        chk("left2_cmd", 32'(c), 1);
        serve(0, 0, 0, 0, 1, cyc, c);
        chk("left3_cmd", 32'(c), 2);

        // barrier, dead end, goal
        serve(1, 1, 0, 1, 1, cyc, c);
        chk("barrier_cmd", 32'(c), 4);
        serve(1, 1, 0, 0, 1, cyc, c);
        chk("deadend_cmd", 32'(c), 3);
        chk("deadend_steps", 32'(bus.steps), 8);
        serve(0, 1, 1, 0, 0, cyc, c);
        step();
        chk("goal_done", 32'(bus.done), 1);
        chk("goal_busy", 32'(bus.busy), 0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.sense_req === 1'b1) seen = 1'b1;
        end
        chk("goal_no_sense", 32'(seen), 0);
        chk("goal_done_held", 32'(bus.done), 1);

        // manual: left and right rise together, left wins, one cycle later
        bus.manual_mode = 1'b1;
        step(); step();
        chk("manual_done_clr", 32'(bus.done), 0);
        bus.gamepad_input = 12'h006;
        step();
        chk("man_lat_early", 32'(bus.cmd_valid), 0);
        step();
        chk("man_prio_valid", 32'(bus.cmd_valid), 1);
        chk("man_prio_cmd",   32'(bus.cmd), 2);
        bus.cmd_ack = 1'b1;
        step();
        bus.cmd_ack = 1'b0;
        chk("man_ack_valid", 32'(bus.cmd_valid), 0);
        chk("man_ack_cmd",   32'(bus.cmd), 0);
        chk("man_ack_steps", 32'(bus.steps), 9);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus.cmd_valid === 1'b1) seen = 1'b1;
        end
        chk("man_hold_norepeat", 32'(seen), 0);
        bus.gamepad_input = 12'h000;
        step(); step();
        bus.gamepad_input = 12'h009;
        step(); step();
        chk("man_repress_valid", 32'(bus.cmd_valid), 1);
        chk("man_repress_cmd",   32'(bus.cmd), 1);
        bus.cmd_ack = 1'b1;
        step();
        bus.cmd_ack = 1'b0;
        chk("man_repress_steps", 32'(bus.steps), 10);

        // ISSUE timeout: no ack for 15 cycles
        bus.gamepad_input = 12'h000;
        step(); step();
        bus.gamepad_input = 12'h004;
        step(); step();
        chk("to_issue_cmd", 32'(bus.cmd), 3);
        repeat (14) step();
        chk("to_cyc14_valid", 32'(bus.cmd_valid), 1);
        chk("to_cyc14_error", 32'(bus.error), 0);
        step();
        chk("to_error",     32'(bus.error), 1);
        chk("to_valid_off", 32'(bus.cmd_valid), 0);
        chk("to_busy",      32'(bus.busy), 0);
        bus.manual_mode = 1'b0;
        bus.gamepad_input = 12'h000;
        repeat (5) step();
        chk("to_sticky",  32'(bus.error), 1);
        chk("to_steps",   32'(bus.steps), 10);

        // ack in the 15th ISSUE cycle is accepted
        rst_n = 1'b0;
        bus.manual_mode = 1'b1;
        step();
        rst_n = 1'b1;
        chk("rst2_error", 32'(bus.error), 0);
        chk("rst2_steps", 32'(bus.steps), 0);
        step();
        bus.gamepad_input = 12'h002;
        step(); step();
        chk("late_valid", 32'(bus.cmd_valid), 1);
        repeat (14) step();
        bus.cmd_ack = 1'b1;
        step();
        bus.cmd_ack = 1'b0;
        chk("late_error", 32'(bus.error), 0);
        chk("late_valid_off", 32'(bus.cmd_valid), 0);
        chk("late_steps", 32'(bus.steps), 1);

        // WAIT_SENSE timeout
        bus.gamepad_input = 12'h000;
        bus.manual_mode = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        cyc = 0;
        while (bus.sense_req !== 1'b1 && cyc < 40) begin step(); cyc++; end
        chk("ws_req_latency", 32'(cyc), 5);
        step();
        repeat (14) step();
        chk("ws_cyc14_error", 32'(bus.error), 0);
        chk("ws_cyc14_busy",  32'(bus.busy), 1);
        step();
        chk("ws_error", 32'(bus.error), 1);

        // reset while cmd_valid is high, then autonomous resumes
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus.manual_mode = 1'b1;
        step();
        bus.gamepad_input = 12'h001;
        step(); step();
        chk("mid_valid", 32'(bus.cmd_valid), 1);
        rst_n = 1'b0;
        bus.manual_mode = 1'b0;
        step();
        chk("mid_rst_valid", 32'(bus.cmd_valid), 0);
        chk("mid_rst_cmd",   32'(bus.cmd), 0);
        chk("mid_rst_req",   32'(bus.sense_req), 0);
        chk("mid_rst_busy",  32'(bus.busy), 0);
        chk("mid_rst_steps", 32'(bus.steps), 0);
        rst_n = 1'b1;
        serve(0, 1, 0, 0, 1, cyc, c);
        chk("resume_latency", 32'(cyc), 8);
        chk("resume_cmd",     32'(c), 1);
        chk("resume_steps",   32'(bus.steps), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/robo_controller.md
# robo_controller

Autonomous/manual motion sequencer for the maze robot. Sits between the gamepad decoder and the map memory block: it requests sensor snapshots (head, left, under, barrier), applies a left-hand wall-following rule, and issues one motion command at a time through a valid/ack handshake. In manual mode it forwards edge-detected gamepad buttons as commands instead. It also tracks progress, completion and handshake timeouts.

## Interface
- STEP_CYCLES, 4: idle cycles between autonomous steps (pacing); legal range 1–255.
- TIMEOUT, 15: maximum cycles to wait for sense_valid or cmd_ack before error; legal range 1–255.

- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- manual_mode  in  1  1 = gamepad drives the robot, 0 = autonomous wall-following.
- gamepad_input  in  12  raw buttons, level-sensitive.
  - [0] forward; [1] turn left; [2] turn right; [3] remove barrier; others ignored.
- head  in  1  wall ahead. Sensor inputs are sampled only in the cycle sense_valid=1.
- left  in  1  wall on left.
- under  in  1  goal cell under robot.
- barrier  in  1  removable barrier ahead.
- sense_valid  in  1  sensor snapshot valid, one-cycle pulse.
- cmd_ack  in  1  memory accepted cmd.
- sense_req  out  1  one-cycle request for a sensor snapshot.
- cmd_valid  out  1  cmd is valid; held until acked.
- cmd  out  3  command encoding.
  - 1 = forward, 2 = turn left, 3 = turn right, 4 = remove.
  - 0 when cmd_valid=0.
- busy  out  1  high in any state other than IDLE, DONE or ERROR.
- done  out  1  goal reached (sticky).
- error  out  1  handshake timeout (sticky).
- steps  out  16  count of acked commands; saturates at 65535.

## Operation
- States: IDLE, WAIT_STEP, SENSE, WAIT_SENSE, DECIDE, ISSUE, DONE, ERROR.
- IDLE:
  - If manual_mode=1 and a rising edge occurs on any of gamepad_input[3:0], go to ISSUE with the command from the lowest-index edge. Priority is forward > left > right > remove.
  - If manual_mode=0, go to WAIT_STEP.
- WAIT_STEP:
  - Count STEP_CYCLES cycles, then go to SENSE.
  - If manual_mode rises during the count, return to IDLE.
- SENSE: assert sense_req for 1 cycle, then go to WAIT_SENSE.
- WAIT_SENSE:
  - On sense_valid, latch the four sensors and go to DECIDE.
  - If TIMEOUT cycles pass without sense_valid, go to ERROR.
- DECIDE (one cycle). The first matching rule wins:
  1. under=1 → DONE.
  2. barrier=1 → cmd remove.
  3. left=0 and last_left=0 → cmd turn left.
  4. head=0 → cmd forward.
  5. Otherwise → cmd turn right.
- last_left:
  - Set when a turn-left command is acked.
  - Cleared when any other command is acked.
  - Cleared on entering manual mode.
- ISSUE:
  - Hold cmd_valid=1 and cmd stable until cmd_ack=1 is sampled.
  - On ack: increment steps, then go to IDLE.
  - If TIMEOUT cycles pass without ack, go to ERROR.
- manual_mode changes during SENSE, WAIT_SENSE, DECIDE or ISSUE do not abort the transaction; the new mode takes effect at the next IDLE.
- DONE: holds done=1. Leaves to IDLE (clearing done) only when manual_mode=1.
- ERROR: sticky; only reset exits.
- Gamepad edge detector: previous-sample register, updated every cycle in every state.
  - Edges arriving outside IDLE are dropped (not queued).
- Reset values:
  - State: IDLE.
  - Outputs: sense_req=0, cmd_valid=0, cmd=0, busy=0, done=0, error=0, steps=0.
  - Internal: last_left=0, all counters 0, gamepad previous-sample register = 0.
  - A gamepad button held through reset produces an edge on the first cycle after reset.

## Timing
- Reset is sampled at the rising edge. Asserting it mid-handshake drops cmd_valid/sense_req at the next edge. No partial command is counted.
- Autonomous loop, minimum cycles per step with zero-latency memory:
  - STEP_CYCLES (WAIT_STEP) + 1 (SENSE) + 1 (WAIT_SENSE) + 1 (DECIDE) + 1 (ISSUE) + 1 (IDLE).
  - = STEP_CYCLES + 5.
- sense_req is high exactly the one cycle in SENSE.
- sense_valid sampled in that same cycle is ignored; it is accepted only in WAIT_SENSE.
- Manual latency: button edge sampled at edge N gives cmd_valid=1 after edge N+1.
- Ack handshake:
  - Ack sampled at edge M gives cmd_valid=0 and cmd=0 after edge M, and steps incremented after edge M.
  - An ack in the very first ISSUE cycle is legal.
- Timeout counter restarts on entry to WAIT_SENSE and to ISSUE.
  - Error is entered after exactly TIMEOUT waiting cycles with no response.
  - A response arriving in the TIMEOUT-th cycle is accepted.
- steps at 65535 stays at 65535 after a further ack.

## Test plan
- **Corridor forward:** auto mode, STEP_CYCLES=4, memory replies each sense with head=0, left=1, under=0, barrier=0 and acks immediately.
  - Expect cmd=1 repeated, first cmd_valid 9 cycles after reset release, period 9 cycles, steps incrementing.
- **Left turn then forward:** one snapshot with left=0, head=0, then the same snapshot again.
  - Expect cmd=2, then cmd=1 (last_left suppresses a second turn left).
- **Barrier, dead end, goal:** snapshots barrier=1 → cmd=4; head=1, left=1 → cmd=3; under=1 → DONE with done=1, busy=0 and no further sense_req.
- **Manual priority:** manual_mode=1, gamepad_input[2] and [1] rise in the same cycle.
  - Expect a single cmd=2 one cycle later.
  - Holding the buttons produces no repeat command; release and re-press produces a new command.
- **Timeouts:** TIMEOUT=15, withhold cmd_ack → error=1 after 15 ISSUE cycles, cmd_valid=0, sticky until reset. Repeat with ack in cycle 15 → accepted, steps=1, error=0.
- **Reset mid-ISSUE:** assert reset while cmd_valid=1 → next cycle all outputs 0, steps=0, state IDLE; with manual_mode=0 the robot resumes sensing.
